// File: rtl/fetch_queue_if.sv
// Fetch queue port bundle: ROM address/data, redirect,
// and the valid/ready handshake toward decode.
interface fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] rom_addr_o;
   logic [31:0]     instruction_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            instr_valid_o;
   logic            instr_ready_i;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] pc_o;
   logic [CW-1:0]   count_o;

   // fetch side: owns the PC and the queue
   modport master (
      output rom_addr_o, instr_valid_o, instr_o, pc_o, count_o,
      input  instruction_i, redirect_i, redirect_pc_i, instr_ready_i
   );

   // ROM, branch unit and decode side
   modport slave (
      input  rom_addr_o, instr_valid_o, instr_o, pc_o, count_o,
      output instruction_i, redirect_i, redirect_pc_i, instr_ready_i
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register plus a DEPTH-entry
// FIFO of {instruction, pc} handed to decode via valid/ready.
module fetch_queue #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [31:0]     mem_instr [DEPTH];
   logic [XLEN-1:0] mem_pc    [DEPTH];

   logic valid;
   logic pop;
   logic push;

   // handshake decode; a full queue still accepts when popping
   always_comb begin
      valid = (count != '0);
      pop   = valid && bus.instr_ready_i;
      push  = !bus.redirect_i && ((count != FULL) || pop);
   end

   // PC, pointers and occupancy; redirect flushes everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (bus.redirect_i) begin
         fetch_pc <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            tail     <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // entry storage; contents are only observed while valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[tail] <= bus.instruction_i;
         mem_pc[tail]    <= fetch_pc;
      end
   end

   // registered head presentation, NOP/0 when empty
   always_comb begin
      bus.rom_addr_o    = fetch_pc;
      bus.instr_valid_o = valid;
      bus.count_o       = count;
      bus.instr_o       = NOP_INSTR;
      bus.pc_o          = '0;
      if (valid) begin
         bus.instr_o = mem_instr[head];
         bus.pc_o    = mem_pc[head];
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized + directed bench for fetch_queue with a
// queue-based reference model and a negedge monitor.
module tb_fetch_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] RPC = 32'h00000100;

   logic clk = 0;
   logic reset = 0;
   logic started = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus2 ();

   fetch_queue #(
      .XLEN(XLEN), .DEPTH(DEPTH),
      .RESET_PC(RPC), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   fetch_queue #(
      .XLEN(XLEN), .DEPTH(DEPTH),
      .RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)
   ) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C0F96;
   endfunction

   assign bus.instruction_i  = rom(bus.rom_addr_o);
   assign bus2.instruction_i = rom(bus2.rom_addr_o);
   assign bus2.redirect_i    = 1'b0;
   assign bus2.redirect_pc_i = '0;
   assign bus2.instr_ready_i = 1'b1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: list of fetched {instr,pc} and next PC
   logic [63:0]     exp_q[$];
   logic [XLEN-1:0] mpc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         mpc <= RPC;
      end else if (bus.redirect_i) begin
         exp_q.delete();
         mpc <= bus.redirect_pc_i & ~32'd3;
      end else begin
         bit do_pop;
         bit do_push;
         do_pop  = (exp_q.size() > 0) && bus.instr_ready_i;
         do_push = (exp_q.size() < DEPTH) || do_pop;
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back({rom(mpc), mpc});
            mpc <= mpc + 32'd4;
         end
      end
   end

   // monitor: compare presented head and occupancy each cycle
   always @(negedge clk) begin
      if (started) begin
         chk("count", 64'(bus.count_o), 64'(exp_q.size()));
         chk("rom_addr", 64'(bus.rom_addr_o), 64'(mpc));
         chk("valid", 64'(bus.instr_valid_o),
             64'(exp_q.size() != 0));
         if (exp_q.size() != 0)
            chk("head", {bus.instr_o, bus.pc_o}, exp_q[0]);
         else
            chk("empty_head", {bus.instr_o, bus.pc_o}, {NOP, 32'd0});
      end
   end

   initial begin
      bus.instr_ready_i = 0;
      bus.redirect_i    = 0;
      bus.redirect_pc_i = '0;
      #1 reset = 1;
      #1 started = 1;
      repeat (2) @(negedge clk);
      chk("rst_rom", 64'(bus.rom_addr_o), 64'(RPC));
      chk("rst_valid", 64'(bus.instr_valid_o), 64'd0);
      chk("rst_instr", 64'(bus.instr_o), 64'(NOP));
      reset = 0;

      @(negedge clk);
      chk("first_valid", 64'(bus.instr_valid_o), 64'd1);
      chk("first_pc", 64'(bus.pc_o), 64'h100);
      chk("first_instr", 64'(bus.instr_o), 64'(rom(32'h100)));
      chk("first_rom", 64'(bus.rom_addr_o), 64'h104);
      chk("wrap_pc0", 64'(bus2.pc_o), 64'hFFFFFFFC);
      chk("wrap_cnt", 64'(bus2.count_o), 64'd1);
      @(negedge clk);
      chk("wrap_pc1", 64'(bus2.pc_o), 64'h0);
      @(negedge clk);
      chk("wrap_pc2", 64'(bus2.pc_o), 64'h4);
      chk("cnt3", 64'(bus.count_o), 64'd3);

      bus.redirect_i    = 1;
      bus.redirect_pc_i = 32'h203;
      @(negedge clk);
      bus.redirect_i = 0;
      chk("rd_count", 64'(bus.count_o), 64'd0);
      chk("rd_valid", 64'(bus.instr_valid_o), 64'd0);
      chk("rd_rom", 64'(bus.rom_addr_o), 64'h200);
      @(negedge clk);
      chk("rd_valid2", 64'(bus.instr_valid_o), 64'd1);
      chk("rd_pc", 64'(bus.pc_o), 64'h200);
      repeat (4) @(negedge clk);
      chk("full_cnt", 64'(bus.count_o), 64'd4);
      chk("full_rom", 64'(bus.rom_addr_o), 64'h210);
      chk("full_pc", 64'(bus.pc_o), 64'h200);

      bus.instr_ready_i = 1;
      @(negedge clk);
      bus.instr_ready_i = 0;
      chk("pp_cnt", 64'(bus.count_o), 64'd4);
      chk("pp_pc", 64'(bus.pc_o), 64'h204);
      chk("pp_rom", 64'(bus.rom_addr_o), 64'h214);

      bus.instr_ready_i = 1;
      bus.redirect_i    = 1;
      bus.redirect_pc_i = 32'h3FE;
      @(negedge clk);
      bus.instr_ready_i = 0;
      bus.redirect_i    = 0;
      chk("rdf_count", 64'(bus.count_o), 64'd0);
      chk("rdf_valid", 64'(bus.instr_valid_o), 64'd0);
      chk("rdf_rom", 64'(bus.rom_addr_o), 64'h3FC);

      repeat (2) @(negedge clk);
      chk("ar_cnt2", 64'(bus.count_o), 64'd2);
      @(posedge clk);
      #3 reset = 1;
      #1;
      chk("ar_valid", 64'(bus.instr_valid_o), 64'd0);
      chk("ar_count", 64'(bus.count_o), 64'd0);
      chk("ar_rom", 64'(bus.rom_addr_o), 64'(RPC));
      chk("ar_instr", 64'(bus.instr_o), 64'(NOP));
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("ar_pc", 64'(bus.pc_o), 64'(RPC));

      bus.instr_ready_i = 1;
      repeat (6) @(negedge clk);
      chk("stream_cnt", 64'(bus.count_o), 64'd1);

      for (int i = 0; i < 400; i++) begin
         bus.instr_ready_i = ($urandom_range(3) != 0);
         bus.redirect_i    = ($urandom_range(15) == 0);
         bus.redirect_pc_i = $urandom;
         @(negedge clk);
      end
      bus.redirect_i = 0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end: it owns the PC and drives the instruction ROM address. It captures each fetched word together with its PC into a DEPTH-entry FIFO and presents entries to decode over a valid/ready handshake. A taken branch from EX/MEM redirects the PC and flushes the queue. It sits between the ROM and the decode stage, and replaces the single-entry fetch register with a decoupled, stallable buffer.

Parameters:
XLEN, 32, width of PC and address paths
DEPTH, 4, number of queue entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h00000013, value driven on instr_o while the queue is empty

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
rom_addr_o  output  XLEN  fetch address to instruction ROM (combinational ROM, data same cycle)
instruction_i  input  32  ROM data for rom_addr_o
redirect_i  input  1  taken branch/jump: flush queue, reload PC
redirect_pc_i  input  XLEN  redirect target
instr_valid_o  output  1  head entry valid
instr_ready_i  input  1  decode accepts head entry
instr_o  output  32  head instruction
pc_o  output  XLEN  PC of head instruction
count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, takes effect immediately on reset=1; active-high):
  - fetch_pc = RESET_PC; head/tail pointers = 0; count = 0.
  - instr_valid_o = 0, instr_o = NOP_INSTR, pc_o = 0, count_o = 0, rom_addr_o = RESET_PC.
- rom_addr_o = fetch_pc register; there is no combinational path from any input to rom_addr_o.
- pop = instr_valid_o && instr_ready_i.
- push = !redirect_i && (count < DEPTH || pop).
  - Push means a full queue accepts a push in the same cycle as a pop.
- Priority per clock edge:
  - If redirect_i:
    - count <= 0 and head/tail pointers <= 0.
    - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}; misaligned low bits are silently cleared.
    - No push this cycle.
    - A pop asserted in the same cycle counts as accepted by decode; the queue is cleared regardless.
  - Else:
    - On push: write {instruction_i, fetch_pc} to entry[tail]; tail <= tail+1 mod DEPTH; fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
    - On pop: head <= head+1 mod DEPTH.
    - count <= count + push - pop.
- Outputs:
  - instr_valid_o = (count != 0).
  - instr_o / pc_o = entry[head] when valid, else NOP_INSTR / 0.
  - Head outputs are registered state, so there is no bypass from instruction_i to instr_o.
  - Minimum latency is 1 cycle: the word at address A appears on instr_o the cycle after rom_addr_o = A.
- Throughput: 1 instruction/cycle sustained when instr_ready_i = 1.
- Full (count = DEPTH) and no pop: fetch_pc holds and rom_addr_o is stable; the ROM word is re-read next cycle.
- Empty: pop is impossible because valid = 0; instr_ready_i is ignored.
- instr_o/pc_o must hold stable while instr_valid_o = 1 and instr_ready_i = 0, except on redirect.
- Pointer wrap uses $clog2(DEPTH) bits; count uses one extra bit so that full and empty are distinguishable.

Test Plan:
- Reset and first fetch:
  - Stimulus: RESET_PC=0x100; hold reset=1, then release with instr_ready_i=0.
  - Required: rom_addr_o=0x100, instr_valid_o=0, instr_o=0x00000013 during reset.
  - Required: first edge after release gives valid=1, pc_o=0x100, instr_o=ROM[0x100], rom_addr_o=0x104.
- Streaming:
  - Stimulus: instr_ready_i=1 continuously.
  - Required: pc_o sequence 0x100, 0x104, 0x108, ... one per cycle; count_o stays 1.
- Backpressure/full:
  - Stimulus: instr_ready_i=0 from reset, DEPTH=4.
  - Required: count_o reaches 4; rom_addr_o holds 0x110; instr_o/pc_o stay at 0x100.
  - Stimulus: then instr_ready_i=1 for exactly one cycle.
  - Required: simultaneous push+pop, count_o stays 4, pc_o becomes 0x104, rom_addr_o becomes 0x114.
- Redirect flush:
  - Stimulus: with count_o=3, pulse redirect_i=1, redirect_pc_i=0x203.
  - Required next cycle: count_o=0, instr_valid_o=0, rom_addr_o=0x200.
  - Required cycle after: valid=1, pc_o=0x200.
  - Stimulus: redirect_i=1 with queue full and ready=1.
  - Required: same flush result.
- PC wrap:
  - Stimulus: RESET_PC=0xFFFFFFFC, instr_ready_i=1.
  - Required: pc_o sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with count_o=2.
  - Required: before the next edge, outputs show valid=0, count_o=0, rom_addr_o=RESET_PC, instr_o=NOP_INSTR.
  - Required: after release, the sequence restarts from RESET_PC.
